vid_tim_gen: RTL and testbench
==============================

VID_TIM_GEN -- requirements
Module: vid_tim_gen

Interface
REQ-001 SHALL have parameter HW, default 16: width of all horizontal timing inputs and the pixel counter.
REQ-002 SHALL have parameter VW, default 12: width of all vertical timing inputs and the line counter.
REQ-003 SHALL have parameter HS_POL, default 1: active level of hsync.
REQ-004 SHALL have parameter VS_POL, default 1: active level of vsync.
REQ-005 SHALL have port clk  in  1  master clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port ena  in  1  count enable (pixel-rate strobe).
REQ-008 SHALL have port trig  in  1  frame start request.
REQ-009 SHALL have port mode  in  1  0 = triggered single frame, 1 = free-running.
REQ-010 SHALL have ports Thsync, Thbp, Thact, Thfp  in  HW each  horizontal sync, back porch, active and front porch lengths in ena-cycles.
REQ-011 SHALL have ports Tvsync, Tvbp, Tvact, Tvfp  in  VW each  vertical sync, back porch, active and front porch lengths in lines.
REQ-012 SHALL have port hsync  out  1  horizontal sync, active level HS_POL.
REQ-013 SHALL have port vsync  out  1  vertical sync, active level VS_POL.
REQ-014 SHALL have port daten  out  1  data enable.
REQ-015 SHALL have port sof  out  1  one-clk start-of-frame pulse.
REQ-016 SHALL have port eof  out  1  one-clk end-of-frame pulse.
REQ-017 SHALL have port busy  out  1  high while a frame is in progress.

Function
REQ-018 SHALL use a frame FSM with states IDLE and RUN, a horizontal FSM H_SYNC->H_BP->H_ACT->H_FP->H_SYNC, and a vertical FSM V_SYNC->V_BP->V_ACT->V_FP.
REQ-019 SHALL update state and counters only on clk edges where ena=1; with ena=0 all state holds.
REQ-020 SHALL set a pending flag on any clk edge where trig=1 (independent of ena), and clear it when a frame starts.
REQ-021 SHALL, in IDLE with ena=1 and pending set (or mode=1), enter RUN at H_SYNC/V_SYNC with both counters 0, and capture all eight timing inputs into shadow registers.
REQ-022 SHALL hold each phase for max(T,1) ena-cycles; a programmed 0 is treated as 1.
REQ-023 SHALL advance the vertical FSM by one line at each H_FP->H_SYNC transition; a vertical phase lasts max(T,1) lines.
REQ-024 SHALL end the frame on the last ena-cycle of the last H_FP of V_FP, then:
- restart at H_SYNC/V_SYNC on the next ena-cycle, with no gap and shadow registers re-captured, if mode=1 or pending is set;
- otherwise return to IDLE.
REQ-025 SHALL ignore timing-input changes during a frame; the shadow values remain in force until the next frame start.
REQ-026 SHALL sample mode only at frame boundaries.
REQ-027 SHALL register all outputs from the current state, so each output lags state by exactly one clk.
REQ-028 SHALL drive hsync at its active level while in RUN and H_SYNC, vsync at its active level while in RUN and V_SYNC, and daten=1 while in RUN and H_ACT and V_ACT.
REQ-029 SHALL pulse sof for one clk at the first pixel of each frame and eof for one clk at the last pixel of each frame; both pulses may occur on consecutive clks during back-to-back frames.
REQ-030 SHALL drive busy=1 whenever the frame FSM is in RUN.
REQ-031 SHALL compute counter compares at HW/VW width with no overflow; maximum values (all ones) SHALL be legal.

Reset
REQ-032 SHALL, on the clk edge with rst=1, set the frame FSM to IDLE, both phase FSMs to SYNC, counters to 0, and clear the pending flag.
REQ-033 SHALL, on that same edge, drive hsync=~HS_POL, vsync=~VS_POL, and daten=sof=eof=busy=0.
REQ-034 SHALL abort any frame in progress on rst, and SHALL not latch trig while rst=1.

Verification
REQ-035 SHALL pass, with ena=1, Th=2/1/4/1 and Tv=1/1/2/1, mode=0, a single trig pulse -> one frame of 40 ena-cycles, 5 hsync pulses 2 cycles wide, vsync active for 8 cycles, 8 daten cycles (2 lines x 4), one sof, one eof, then IDLE.
REQ-036 SHALL pass, in mode=1 with the same timing -> continuous 40-cycle frames with no idle cycle between eof and the next sof.
REQ-037 SHALL pass a trig pulse mid-frame in mode=0 -> a second frame starting immediately after eof, with the Th values re-captured at that start.
REQ-038 SHALL pass ena toggling 1/0 every clk -> identical output sequence stretched to 2x duration, with outputs holding during ena=0.
REQ-039 SHALL pass Thbp=0 and Tvfp=0 -> each treated as length 1, giving a line of 8 ena-cycles.
REQ-040 SHALL pass rst asserted mid-active-line with HS_POL=0 -> next clk hsync=1, daten=busy=0; no frame starts until a new trig after rst is released.

Source files
------------

// File: rtl/vid_tim_gen.sv
// Programmable video timing generator: frame/horizontal/vertical phase FSMs
// driving registered sync, data-enable and frame-boundary strobes.
module vid_tim_gen #(
  parameter int unsigned HW     = 16,
  parameter int unsigned VW     = 12,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          trig,
  input  logic          mode,
  input  logic [HW-1:0] Thsync,
  input  logic [HW-1:0] Thbp,
  input  logic [HW-1:0] Thact,
  input  logic [HW-1:0] Thfp,
  input  logic [VW-1:0] Tvsync,
  input  logic [VW-1:0] Tvbp,
  input  logic [VW-1:0] Tvact,
  input  logic [VW-1:0] Tvfp,
  output logic          hsync,
  output logic          vsync,
  output logic          daten,
  output logic          sof,
  output logic          eof,
  output logic          busy
);

  typedef enum logic       {F_IDLE, F_RUN} frame_e;
  typedef enum logic [1:0] {H_SYNC, H_BP, H_ACT, H_FP} hph_e;
  typedef enum logic [1:0] {V_SYNC, V_BP, V_ACT, V_FP} vph_e;

  frame_e frame_q, frame_d;
  hph_e   hst_q, hst_d;
  vph_e   vst_q, vst_d;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          pend_q, pend_d;

  logic [HW-1:0] ths_q, thb_q, tha_q, thf_q;
  logic [HW-1:0] ths_d, thb_d, tha_d, thf_d;
  logic [VW-1:0] tvs_q, tvb_q, tva_q, tvf_q;
  logic [VW-1:0] tvs_d, tvb_d, tva_d, tvf_d;

  logic hsync_q, vsync_q, daten_q, sof_q, eof_q, busy_q;
  logic hsync_d, vsync_d, daten_d, sof_d, eof_d, busy_d;

  logic [HW-1:0] h_t, h_m1;
  logic [VW-1:0] v_t, v_m1;
  logic          h_last, v_last, line_end, frame_end, run, go, start;

  // Length of the current phase; a programmed 0 behaves as 1.
  always_comb begin
    h_t = ths_q;
    case (hst_q)
      H_SYNC:  h_t = ths_q;
      H_BP:    h_t = thb_q;
      H_ACT:   h_t = tha_q;
      default: h_t = thf_q;
    endcase
    v_t = tvs_q;
    case (vst_q)
      V_SYNC:  v_t = tvs_q;
      V_BP:    v_t = tvb_q;
      V_ACT:   v_t = tva_q;
      default: v_t = tvf_q;
    endcase
  end

  assign h_m1      = (h_t == '0) ? '0 : h_t - HW'(1);
  assign v_m1      = (v_t == '0) ? '0 : v_t - VW'(1);
  assign h_last    = (hcnt_q == h_m1);
  assign v_last    = (vcnt_q == v_m1);
  assign line_end  = (hst_q == H_FP) && h_last;
  assign frame_end = line_end && (vst_q == V_FP) && v_last;
  assign run       = (frame_q == F_RUN);
  assign go        = pend_q || mode;
  assign start     = ena && go && (!run || frame_end);

  // Next-state and output decode.
  always_comb begin
    frame_d = frame_q;
    hst_d   = hst_q;
    vst_d   = vst_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    pend_d  = pend_q;
    ths_d   = ths_q;
    thb_d   = thb_q;
    tha_d   = tha_q;
    thf_d   = thf_q;
    tvs_d   = tvs_q;
    tvb_d   = tvb_q;
    tva_d   = tva_q;
    tvf_d   = tvf_q;

    if (ena) begin
      if (run) begin
        if (h_last) begin
          hcnt_d = '0;
          hst_d  = hph_e'(hst_q + 2'd1);
          if (line_end) begin
            if (v_last) begin
              vcnt_d = '0;
              vst_d  = vph_e'(vst_q + 2'd1);
            end else begin
              vcnt_d = vcnt_q + VW'(1);
            end
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
        if (frame_end && !go) frame_d = F_IDLE;
      end
      if (start) begin
        frame_d = F_RUN;
        hst_d   = H_SYNC;
        vst_d   = V_SYNC;
        hcnt_d  = '0;
        vcnt_d  = '0;
        pend_d  = 1'b0;
        ths_d   = Thsync;
        thb_d   = Thbp;
        tha_d   = Thact;
        thf_d   = Thfp;
        tvs_d   = Tvsync;
        tvb_d   = Tvbp;
        tva_d   = Tvact;
        tvf_d   = Tvfp;
      end
    end
    // A request arriving on the start edge itself is kept for the next frame.
    if (trig) pend_d = 1'b1;

    hsync_d = (run && hst_q == H_SYNC) ? HS_POL : ~HS_POL;
    vsync_d = (run && vst_q == V_SYNC) ? VS_POL : ~VS_POL;
    daten_d = run && (hst_q == H_ACT) && (vst_q == V_ACT);
    sof_d   = run && ena && (hst_q == H_SYNC) && (vst_q == V_SYNC) &&
              (hcnt_q == '0) && (vcnt_q == '0);
    eof_d   = run && ena && frame_end;
    busy_d  = run;
  end

  // State, shadow and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= F_IDLE;
      hst_q   <= H_SYNC;
      vst_q   <= V_SYNC;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      pend_q  <= 1'b0;
      ths_q   <= '0;
      thb_q   <= '0;
      tha_q   <= '0;
      thf_q   <= '0;
      tvs_q   <= '0;
      tvb_q   <= '0;
      tva_q   <= '0;
      tvf_q   <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      daten_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      hst_q   <= hst_d;
      vst_q   <= vst_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      pend_q  <= pend_d;
      ths_q   <= ths_d;
      thb_q   <= thb_d;
      tha_q   <= tha_d;
      thf_q   <= thf_d;
      tvs_q   <= tvs_d;
      tvb_q   <= tvb_d;
      tva_q   <= tva_d;
      tvf_q   <= tvf_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      daten_q <= daten_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign daten = daten_q;
  assign sof   = sof_q;
  assign eof   = eof_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_vid_tim_gen.sv
// Directed bench for vid_tim_gen: one active-high sync instance and one
// active-low sync instance driven from the same stimulus.
module tb_vid_tim_gen;

  localparam int unsigned HW = 16;
  localparam int unsigned VW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic          trig = 1'b0;
  logic          mode = 1'b0;
  logic [HW-1:0] Thsync, Thbp, Thact, Thfp;
  logic [VW-1:0] Tvsync, Tvbp, Tvact, Tvfp;

  logic hsync, vsync, daten, sof, eof, busy;
  logic hsync_n, vsync_n, daten_n, sof_n, eof_n, busy_n;

  int checks = 0;
  int failures = 0;

  int n_busy, n_sof, n_eof, n_den, n_hs, n_hs_rise, n_vs, n_nhs, first_den;
  logic prev_hs;
  int sof_q[$];
  int eof_q[$];

  always #5 clk = ~clk;

  vid_tim_gen #(.HW(HW), .VW(VW), .HS_POL(1'b1), .VS_POL(1'b1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .trig(trig), .mode(mode),
    .Thsync(Thsync), .Thbp(Thbp), .Thact(Thact), .Thfp(Thfp),
    .Tvsync(Tvsync), .Tvbp(Tvbp), .Tvact(Tvact), .Tvfp(Tvfp),
    .hsync(hsync), .vsync(vsync), .daten(daten), .sof(sof), .eof(eof), .busy(busy)
  );

  vid_tim_gen #(.HW(HW), .VW(VW), .HS_POL(1'b0), .VS_POL(1'b0)) dut_n (
    .clk(clk), .rst(rst), .ena(ena), .trig(trig), .mode(mode),
    .Thsync(Thsync), .Thbp(Thbp), .Thact(Thact), .Thfp(Thfp),
    .Tvsync(Tvsync), .Tvbp(Tvbp), .Tvact(Tvact), .Tvfp(Tvfp),
    .hsync(hsync_n), .vsync(vsync_n), .daten(daten_n), .sof(sof_n), .eof(eof_n),
    .busy(busy_n)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_timing(input int hs, input int hb, input int ha, input int hf,
                            input int vs, input int vb, input int va, input int vf);
    Thsync = HW'(hs); Thbp = HW'(hb); Thact = HW'(ha); Thfp = HW'(hf);
    Tvsync = VW'(vs); Tvbp = VW'(vb); Tvact = VW'(va); Tvfp = VW'(vf);
  endtask

  task automatic do_reset;
    rst = 1'b1; ena = 1'b1; trig = 1'b0; mode = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_stats;
    n_busy = 0; n_sof = 0; n_eof = 0; n_den = 0; n_hs = 0; n_hs_rise = 0;
    n_vs = 0; n_nhs = 0; first_den = -1; prev_hs = 1'b0;
    sof_q.delete(); eof_q.delete();
  endtask

  task automatic sample(input int i);
    if (busy) n_busy++;
    if (sof) begin n_sof++; sof_q.push_back(i); end
    if (eof) begin n_eof++; eof_q.push_back(i); end
    if (daten) begin
      n_den++;
      if (first_den < 0) first_den = i;
    end
    if (hsync) n_hs++;
    if (hsync && !prev_hs) n_hs_rise++;
    prev_hs = hsync;
    if (vsync) n_vs++;
    if (!hsync_n) n_nhs++;
  endtask

  function automatic int qat(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  task automatic test_reset;
    int nb;
    rst = 1'b1; trig = 1'b1; ena = 1'b1; mode = 1'b0;
    set_timing(2, 1, 4, 1, 1, 1, 2, 1);
    tick();
    checks++;
    if ({hsync, vsync, daten, sof, eof, busy} !== 6'b000000) begin
      failures++; $display("FAIL reset_outs got=%b want=000000", {hsync, vsync, daten, sof, eof, busy});
    end
    checks++;
    if ({hsync_n, vsync_n, daten_n, busy_n} !== 4'b1100) begin
      failures++; $display("FAIL reset_outs_n got=%b want=1100", {hsync_n, vsync_n, daten_n, busy_n});
    end
    rst = 1'b0; trig = 1'b0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (busy) nb++; end
    checks++;
    if (nb !== 0) begin failures++; $display("FAIL reset_no_trig_latch busy_cycles=%0d want=0", nb); end
  endtask

  task automatic test_single_frame;
    do_reset();
    set_timing(2, 1, 4, 1, 1, 1, 2, 1);
    clear_stats();
    for (int i = 0; i < 60; i++) begin
      trig = (i == 0);
      tick();
      sample(i);
    end
    trig = 1'b0;
    checks++; if (n_busy !== 40) begin failures++; $display("FAIL single_busy got=%0d want=40", n_busy); end
    checks++; if (n_sof !== 1 || qat(sof_q, 0) !== 2) begin failures++; $display("FAIL single_sof n=%0d at=%0d want 1 at 2", n_sof, qat(sof_q, 0)); end
    checks++; if (n_eof !== 1 || qat(eof_q, 0) !== 41) begin failures++; $display("FAIL single_eof n=%0d at=%0d want 1 at 41", n_eof, qat(eof_q, 0)); end
    checks++; if (n_hs !== 10 || n_hs_rise !== 5) begin failures++; $display("FAIL single_hsync cyc=%0d pulses=%0d want 10/5", n_hs, n_hs_rise); end
    checks++; if (n_vs !== 8) begin failures++; $display("FAIL single_vsync got=%0d want=8", n_vs); end
    checks++; if (n_den !== 8 || first_den !== 21) begin failures++; $display("FAIL single_daten n=%0d first=%0d want 8/21", n_den, first_den); end
    checks++; if (n_nhs !== 10) begin failures++; $display("FAIL single_hsync_lowpol got=%0d want=10", n_nhs); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle busy=%b want=0", busy); end
  endtask

  task automatic test_free_run;
    int fall;
    do_reset();
    set_timing(2, 1, 4, 1, 1, 1, 2, 1);
    clear_stats();
    mode = 1'b1;
    for (int i = 0; i < 125; i++) begin tick(); sample(i); end
    checks++; if (n_sof !== 4 || qat(sof_q, 1) !== 41 || qat(sof_q, 3) !== 121) begin
      failures++; $display("FAIL free_sof n=%0d s1=%0d s3=%0d want 4/41/121", n_sof, qat(sof_q, 1), qat(sof_q, 3)); end
    checks++; if (n_eof !== 3 || qat(eof_q, 0) !== 40 || qat(eof_q, 2) !== 120) begin
      failures++; $display("FAIL free_eof n=%0d e0=%0d e2=%0d want 3/40/120", n_eof, qat(eof_q, 0), qat(eof_q, 2)); end
    checks++; if (n_busy !== 124) begin failures++; $display("FAIL free_no_gap busy=%0d want=124", n_busy); end
    mode = 1'b0;
    fall = -1;
    for (int i = 125; i < 300 && fall < 0; i++) begin
      tick(); sample(i);
      if (!busy) fall = i;
    end
    checks++; if (fall !== 161 || n_eof !== 4) begin failures++; $display("FAIL free_stop idle_at=%0d eofs=%0d want 161/4", fall, n_eof); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_timing(2, 1, 4, 1, 1, 1, 2, 1);
    clear_stats();
    for (int i = 0; i < 110; i++) begin
      trig = (i == 0) || (i == 20);
      if (i == 5) Thact = HW'(6);
      tick();
      sample(i);
    end
    trig = 1'b0;
    checks++; if (n_sof !== 2 || qat(sof_q, 1) !== 42) begin failures++; $display("FAIL b2b_sof n=%0d s1=%0d want 2/42", n_sof, qat(sof_q, 1)); end
    checks++; if (n_eof !== 2 || qat(eof_q, 0) !== 41 || qat(eof_q, 1) !== 91) begin
      failures++; $display("FAIL b2b_eof n=%0d e0=%0d e1=%0d want 2/41/91", n_eof, qat(eof_q, 0), qat(eof_q, 1)); end
    checks++; if (n_busy !== 90 || n_den !== 20) begin failures++; $display("FAIL b2b_len busy=%0d den=%0d want 90/20", n_busy, n_den); end
  endtask

  task automatic test_ena_toggle;
    do_reset();
    set_timing(2, 1, 4, 1, 1, 1, 2, 1);
    clear_stats();
    for (int i = 0; i < 100; i++) begin
      ena = (i % 2 == 0);
      trig = (i == 0);
      tick();
      sample(i);
    end
    ena = 1'b1; trig = 1'b0;
    checks++; if (n_busy !== 80) begin failures++; $display("FAIL ena_busy got=%0d want=80", n_busy); end
    checks++; if (n_sof !== 1 || qat(sof_q, 0) !== 4 || n_eof !== 1 || qat(eof_q, 0) !== 82) begin
      failures++; $display("FAIL ena_sof_eof sof=%0d@%0d eof=%0d@%0d want 1@4 1@82", n_sof, qat(sof_q, 0), n_eof, qat(eof_q, 0)); end
    checks++; if (n_hs !== 20 || n_hs_rise !== 5 || n_vs !== 16) begin
      failures++; $display("FAIL ena_sync hs=%0d rise=%0d vs=%0d want 20/5/16", n_hs, n_hs_rise, n_vs); end
    checks++; if (n_den !== 16 || first_den !== 41) begin failures++; $display("FAIL ena_daten n=%0d first=%0d want 16/41", n_den, first_den); end
  endtask

  task automatic test_zero_len;
    do_reset();
    set_timing(2, 0, 3, 2, 1, 1, 2, 0);
    clear_stats();
    for (int i = 0; i < 60; i++) begin
      trig = (i == 0);
      tick();
      sample(i);
    end
    trig = 1'b0;
    checks++; if (n_busy !== 40 || qat(eof_q, 0) !== 41) begin failures++; $display("FAIL zero_frame busy=%0d eof_at=%0d want 40/41", n_busy, qat(eof_q, 0)); end
    checks++; if (n_den !== 6 || first_den !== 21) begin failures++; $display("FAIL zero_daten n=%0d first=%0d want 6/21", n_den, first_den); end
    checks++; if (n_hs_rise !== 5 || n_hs !== 10) begin failures++; $display("FAIL zero_hsync rise=%0d cyc=%0d want 5/10", n_hs_rise, n_hs); end
  endtask

  task automatic test_rst_mid_line;
    int nb;
    logic seen;
    do_reset();
    set_timing(2, 1, 4, 1, 1, 1, 2, 1);
    for (int i = 0; i <= 22; i++) begin trig = (i == 0); tick(); end
    trig = 1'b0;
    checks++; if (daten_n !== 1'b1 || busy_n !== 1'b1) begin failures++; $display("FAIL rst_pre_active daten=%b busy=%b want 1/1", daten_n, busy_n); end
    rst = 1'b1;
    tick();
    checks++; if ({hsync_n, vsync_n, daten_n, busy_n} !== 4'b1100) begin
      failures++; $display("FAIL rst_mid_outs got=%b want=1100", {hsync_n, vsync_n, daten_n, busy_n}); end
    rst = 1'b0;
    nb = 0;
    for (int i = 0; i < 60; i++) begin tick(); if (busy_n || busy) nb++; end
    checks++; if (nb !== 0) begin failures++; $display("FAIL rst_no_restart busy_cycles=%0d want=0", nb); end
    rst = 1'b1; trig = 1'b1;
    tick();
    rst = 1'b0; trig = 1'b0;
    nb = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (busy_n) nb++; end
    checks++; if (nb !== 0) begin failures++; $display("FAIL rst_trig_ignored busy_cycles=%0d want=0", nb); end
    trig = 1'b1;
    tick();
    trig = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (busy_n && sof_n) seen = 1'b1; end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rst_new_trig frame_started=%b want=1", seen); end
  endtask

  initial begin
    set_timing(2, 1, 4, 1, 1, 1, 2, 1);
    test_reset();
    test_single_frame();
    test_free_run();
    test_back_to_back();
    test_ena_toggle();
    test_zero_len();
    test_rst_mid_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
